host_src_rr_arbiter: RTL and testbench

- Packet-granular round-robin arbiter that shares one host source stream (the user-logic-to-host stream of a vFPGA region) between N_REQ internal requesters.
- Locks the grant to one requester from its first beat until tlast, so packets are never interleaved.
- Stamps each beat with the requester index on m_tid.
- Has a registered output stage so it can drive the shell's host-source interface directly.

---
 rtl/host_src_rr_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_host_src_rr_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_src_rr_arbiter.sv
// -----------------------------------------------------------------------------
// host_src_rr_arbiter
//
// Packet-granular round-robin arbiter that merges N_REQ requester streams onto
// the single user-logic-to-host source stream of a vFPGA region. Once a
// requester wins, it keeps the grant from its first beat through tlast, so
// packets never interleave. Every beat leaving the block carries the index of
// its requester on m_tid. The output is a single register slice, which lets
// the block drive the shell's host-source interface directly.
//
// Parameters
//   N_REQ      number of requesters (2..16)
//   DATA_BITS  stream data width, a multiple of 8
//   ID_BITS    m_tid width, 2**ID_BITS >= N_REQ
//
// Ports
//   aclk, aresetn          clock (rising edge) and asynchronous active-low reset
//   s_tvalid/s_tready      per-requester handshake, bit i belongs to requester i
//   s_tdata/s_tkeep        requester i at [i*DATA_BITS +: DATA_BITS] and
//                          [i*DATA_BITS/8 +: DATA_BITS/8]
//   s_tlast                per-requester end of packet
//   m_tvalid/m_tready      registered output handshake
//   m_tdata/m_tkeep/m_tlast registered output payload
//   m_tid                  requester index of the beat on the output
//   busy                   high while a packet is granted
//
// Optional feature, enabled by defining HOST_ARB_STATS_EN:
//   stats_sel   selects the requester whose counters are read back
//   stats_clr   synchronously zeroes all counters (wins over an increment)
//   stats_pkts  registered packet count of requester stats_sel
//   stats_beats registered beat count of requester stats_sel
// Without the macro these ports and counters do not exist; arbitration timing
// is the same either way.
// -----------------------------------------------------------------------------
module host_src_rr_arbiter #(
   parameter int N_REQ     = 4,
   parameter int DATA_BITS = 512,
   parameter int ID_BITS   = 4
) (
   input  logic                         aclk,
   input  logic                         aresetn,
   input  logic [N_REQ-1:0]             s_tvalid,
   output logic [N_REQ-1:0]             s_tready,
   input  logic [N_REQ*DATA_BITS-1:0]   s_tdata,
   input  logic [N_REQ*DATA_BITS/8-1:0] s_tkeep,
   input  logic [N_REQ-1:0]             s_tlast,
   output logic                         m_tvalid,
   input  logic                         m_tready,
   output logic [DATA_BITS-1:0]         m_tdata,
   output logic [DATA_BITS/8-1:0]       m_tkeep,
   output logic                         m_tlast,
   output logic [ID_BITS-1:0]           m_tid,
   output logic                         busy
`ifdef HOST_ARB_STATS_EN
   ,
   input  logic [ID_BITS-1:0]           stats_sel,
   input  logic                         stats_clr,
   output logic [31:0]                  stats_pkts,
   output logic [31:0]                  stats_beats
`endif
);

   localparam int KEEP_BITS = DATA_BITS / 8;
   localparam int GW        = $clog2(N_REQ);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t                state_reg;
   logic [GW-1:0]         grant_reg;
   logic [GW-1:0]         last_grant_reg;

   // Per-requester views of the packed payload buses.
   logic [DATA_BITS-1:0]  req_data [N_REQ];
   logic [KEEP_BITS-1:0]  req_keep [N_REQ];

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign req_data[gi] = s_tdata[gi*DATA_BITS +: DATA_BITS];
         assign req_keep[gi] = s_tkeep[gi*KEEP_BITS +: KEEP_BITS];
      end
   endgenerate

   // Payload of the currently granted requester.
   logic                  sel_valid;
   logic                  sel_last;
   logic [DATA_BITS-1:0]  sel_data;
   logic [KEEP_BITS-1:0]  sel_keep;

   assign sel_valid = s_tvalid[grant_reg];
   assign sel_last  = s_tlast[grant_reg];
   assign sel_data  = req_data[grant_reg];
   assign sel_keep  = req_keep[grant_reg];

   // The output slice can accept a beat when it is empty or draining now.
   logic can_load;
   logic in_hs;

   assign can_load = !m_tvalid || m_tready;
   assign in_hs    = (state_reg == BUSY) && sel_valid && can_load;
   assign busy     = (state_reg == BUSY);

   // Only the granted requester ever sees ready; in IDLE nobody does, which
   // is the one-cycle arbitration bubble per packet.
   always_comb begin
      s_tready = '0;
      if (state_reg == BUSY) begin
         s_tready[grant_reg] = can_load;
      end
   end

   // Round-robin pick: first valid requester after the last packet's owner,
   // wrapping around. Priority rotates only at packet boundaries.
   logic          arb_found;
   logic [GW-1:0] arb_pick;
   logic [GW-1:0] cand;

   always_comb begin
      arb_found = 1'b0;
      arb_pick  = '0;
      cand      = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = GW'((int'(last_grant_reg) + k) % N_REQ);
         if (!arb_found && s_tvalid[cand]) begin
            arb_found = 1'b1;
            arb_pick  = cand;
         end
      end
   end

   // Grant FSM and output register slice.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_reg      <= IDLE;
         grant_reg      <= '0;
         last_grant_reg <= GW'(N_REQ - 1);
         m_tvalid       <= 1'b0;
         m_tdata        <= '0;
         m_tkeep        <= '0;
         m_tlast        <= 1'b0;
         m_tid          <= '0;
      end else begin
         if (in_hs) begin
            m_tvalid <= 1'b1;
            m_tdata  <= sel_data;
            m_tkeep  <= sel_keep;
            m_tlast  <= sel_last;
            m_tid    <= ID_BITS'(grant_reg);
         end else if (m_tready) begin
            m_tvalid <= 1'b0;
         end

         case (state_reg)
            IDLE: begin
               if (arb_found) begin
                  grant_reg <= arb_pick;
                  state_reg <= BUSY;
               end
            end
            BUSY: begin
               // A stalled requester keeps the grant for as long as it likes.
               if (in_hs && sel_last) begin
                  last_grant_reg <= grant_reg;
                  state_reg      <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

`ifdef HOST_ARB_STATS_EN
   // Per-requester packet and beat counters with a registered read port.
   logic [31:0] pkt_cnt_all  [N_REQ];
   logic [31:0] beat_cnt_all [N_REQ];

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stats
         logic [31:0] pkt_cnt_reg;
         logic [31:0] beat_cnt_reg;
         logic        hit;

         assign hit = in_hs && (grant_reg == GW'(gi));

         always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
               pkt_cnt_reg  <= '0;
               beat_cnt_reg <= '0;
            end else if (stats_clr) begin
               pkt_cnt_reg  <= '0;
               beat_cnt_reg <= '0;
            end else if (hit) begin
               beat_cnt_reg <= beat_cnt_reg + 32'd1;
               if (sel_last) begin
                  pkt_cnt_reg <= pkt_cnt_reg + 32'd1;
               end
            end
         end

         assign pkt_cnt_all[gi]  = pkt_cnt_reg;
         assign beat_cnt_all[gi] = beat_cnt_reg;
      end
   endgenerate

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         stats_pkts  <= '0;
         stats_beats <= '0;
      end else if (int'(stats_sel) < N_REQ) begin
         stats_pkts  <= pkt_cnt_all[stats_sel[GW-1:0]];
         stats_beats <= beat_cnt_all[stats_sel[GW-1:0]];
      end else begin
         // Selecting a requester that does not exist reads as zero.
         stats_pkts  <= '0;
         stats_beats <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_host_src_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_host_src_rr_arbiter
//
// Scoreboard bench for host_src_rr_arbiter. Requester drivers push every beat
// they issue into a per-requester expected queue; a negedge monitor pops and
// compares whenever the output handshakes. A round-robin reference (winner =
// first requesting index after the previous packet's owner, evaluated at the
// first cycle anyone requests once the arbiter has gone idle) predicts the
// m_tid of every packet and which s_tready bit may be high.
// Define HOST_ARB_STATS_EN to include the counter checks.
// -----------------------------------------------------------------------------
module tb_host_src_rr_arbiter;

   localparam int N  = 4;
   localparam int DB = 32;
   localparam int KB = DB / 8;
   localparam int IB = 4;

   logic               aclk = 1'b0;
   logic               aresetn;
   logic [N-1:0]       s_tvalid;
   logic [N-1:0]       s_tready;
   logic [N*DB-1:0]    s_tdata;
   logic [N*KB-1:0]    s_tkeep;
   logic [N-1:0]       s_tlast;
   logic               m_tvalid;
   logic               m_tready;
   logic [DB-1:0]      m_tdata;
   logic [KB-1:0]      m_tkeep;
   logic               m_tlast;
   logic [IB-1:0]      m_tid;
   logic               busy;
`ifdef HOST_ARB_STATS_EN
   logic [IB-1:0]      stats_sel;
   logic               stats_clr;
   logic [31:0]        stats_pkts;
   logic [31:0]        stats_beats;
`endif

   host_src_rr_arbiter #(.N_REQ(N), .DATA_BITS(DB), .ID_BITS(IB)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
      .s_tkeep(s_tkeep), .s_tlast(s_tlast),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
      .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tid(m_tid), .busy(busy)
`ifdef HOST_ARB_STATS_EN
      , .stats_sel(stats_sel), .stats_clr(stats_clr),
      .stats_pkts(stats_pkts), .stats_beats(stats_beats)
`endif
   );

   always #5 aclk = ~aclk;

   // Per-requester driver state, packed onto the DUT buses.
   logic          tv [N];
   logic [DB-1:0] td [N];
   logic [KB-1:0] tk [N];
   logic          tl [N];

   always_comb begin
      s_tvalid = '0;
      s_tdata  = '0;
      s_tkeep  = '0;
      s_tlast  = '0;
      for (int i = 0; i < N; i++) begin
         s_tvalid[i]          = tv[i];
         s_tdata[i*DB +: DB]  = td[i];
         s_tkeep[i*KB +: KB]  = tk[i];
         s_tlast[i]           = tl[i];
      end
   end

   typedef struct packed {
      logic [DB-1:0] d;
      logic [KB-1:0] k;
      logic          l;
   } beat_t;

   beat_t exp_q [N][$];
   int    grant_q[$];
   int    tid_log[$];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++) begin
         if (v[(last + k) % N]) return (last + k) % N;
      end
      return 0;
   endfunction

   // ---------------- reference model + monitor ----------------
   int            last_g, cur_g, out_tid;
   bit            arb_pending, active, out_mid, hs_prev, hold_prev, log_en;
   logic [40:0]   hold_word;

   always @(negedge aclk) begin
      if (!aresetn) begin
         arb_pending = 1'b1;
         last_g      = N - 1;
         cur_g       = 0;
         active      = 1'b0;
         out_mid     = 1'b0;
         hs_prev     = 1'b0;
         hold_prev   = 1'b0;
         out_tid     = 0;
         grant_q.delete();
         for (int i = 0; i < N; i++) exp_q[i].delete();
      end else begin
         logic [N-1:0] exp_rdy;
         bit           hs_now, tl_now, ok;
         beat_t        want;
         int           wg;

         exp_rdy = '0;
         if (active) exp_rdy[cur_g] = !m_tvalid || m_tready;
         chk("s_tready", 64'(s_tready), 64'(exp_rdy));
         chk("busy", 64'(busy), 64'(active));
         chk("m_tvalid", 64'(m_tvalid), 64'(hs_prev || hold_prev));
         if (hold_prev && m_tvalid)
            chk("hold_stable", 64'({m_tdata, m_tkeep, m_tlast, m_tid}), 64'(hold_word));

         if (m_tvalid && m_tready) begin
            if (!out_mid) begin
               chk("grant_expected", 64'(grant_q.size() != 0), 64'd1);
               if (grant_q.size() != 0) begin
                  wg = grant_q.pop_front();
                  chk("m_tid_first", 64'(m_tid), 64'(wg));
                  if (log_en) tid_log.push_back(int'(m_tid));
               end
               out_tid = int'(m_tid);
            end else begin
               chk("m_tid_mid", 64'(m_tid), 64'(out_tid));
            end
            ok = 1'b0;
            if (int'(m_tid) < N) ok = (exp_q[m_tid].size() != 0);
            chk("beat_expected", 64'(ok), 64'd1);
            if (ok) begin
               want = exp_q[m_tid].pop_front();
               chk("beat", 64'({m_tdata, m_tkeep, m_tlast}), 64'(want));
            end
            out_mid = !m_tlast;
         end

         hold_prev = m_tvalid && !m_tready;
         hold_word = {m_tdata, m_tkeep, m_tlast, m_tid};

         hs_now = 1'b0;
         tl_now = 1'b0;
         for (int r = 0; r < N; r++) begin
            if (tv[r] && s_tready[r]) begin
               hs_now = 1'b1;
               if (tl[r]) tl_now = 1'b1;
            end
         end
         hs_prev = hs_now;

         if (arb_pending && (s_tvalid != '0)) begin
            cur_g = rr_pick(s_tvalid, last_g);
            grant_q.push_back(cur_g);
            arb_pending = 1'b0;
            active      = 1'b1;
         end else if (tl_now) begin
            last_g      = cur_g;
            active      = 1'b0;
            arb_pending = 1'b1;
         end
      end
   end

   // ---------------- stimulus ----------------
   // base < 0 gives random data; stall_at selects a beat preceded by a
   // stall of stall_len cycles with tvalid low.
   task automatic send_pkt(input int r, input int nb, input int base,
                           input int gap_pct, input int stall_at, input int stall_len);
      for (int b = 0; b < nb; b++) begin
         beat_t bt;
         bit    hs;
         int    n;
         if (b > 0 && gap_pct > 0) begin
            while ($urandom_range(99) < gap_pct) begin
               tv[r] = 1'b0;
               @(posedge aclk); #1;
            end
         end
         if (b == stall_at) begin
            tv[r] = 1'b0;
            repeat (stall_len) @(posedge aclk);
            #1;
         end
         bt.d = (base < 0) ? DB'($urandom) : DB'(base + b);
         bt.k = KB'($urandom);
         bt.l = (b == nb - 1);
         exp_q[r].push_back(bt);
         tv[r] = 1'b1; td[r] = bt.d; tk[r] = bt.k; tl[r] = bt.l;
         hs = 1'b0;
         n  = 0;
         while (!hs && n < 2000) begin
            @(negedge aclk);
            hs = s_tready[r];
            @(posedge aclk); #1;
            n++;
         end
         chk("handshake_wait", 64'(hs), 64'd1);
      end
      tv[r] = 1'b0;
      tl[r] = 1'b0;
   endtask

   task automatic rand_req(input int r);
      repeat (6) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge aclk); #1;
         end
         send_pkt(r, int'($urandom_range(1, 4)), -1, 30, -1, 0);
      end
   endtask

   task automatic drain();
      int n, left;
      m_tready = 1'b1;
      n = 0;
      left = 1;
      while (left != 0 && n < 500) begin
         left = 0;
         for (int i = 0; i < N; i++) left += exp_q[i].size();
         @(posedge aclk); #1;
         n++;
      end
      repeat (2) @(posedge aclk);
      #1;
      chk("drain_left", 64'(left), 64'd0);
      chk("drain_grants", 64'(grant_q.size()), 64'd0);
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      repeat (2) @(posedge aclk);
      #1;
      aresetn = 1'b1;
   endtask

   initial begin
      repeat (60000) @(posedge aclk);
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   bit rand_done;

   initial begin
      int exp_order [12];
      for (int i = 0; i < N; i++) begin
         tv[i] = 1'b0; td[i] = '0; tk[i] = '0; tl[i] = 1'b0;
      end
      m_tready  = 1'b1;
      log_en    = 1'b0;
      rand_done = 1'b0;
`ifdef HOST_ARB_STATS_EN
      stats_sel = '0;
      stats_clr = 1'b0;
`endif
      aresetn = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      aresetn = 1'b1;

      // Idle after reset.
      repeat (10) begin
         @(negedge aclk);
         chk("idle_m_tvalid", 64'(m_tvalid), 64'd0);
         chk("idle_s_tready", 64'(s_tready), 64'd0);
         chk("idle_busy", 64'(busy), 64'd0);
      end
      chk("idle_m_tdata", 64'(m_tdata), 64'd0);
      @(posedge aclk); #1;

      // Requester 2 alone, data A0..A3.
      send_pkt(2, 4, 'hA0, 0, -1, 0);
      drain();

      // All requesters back-to-back 2-beat packets from reset.
      do_reset();
      tid_log.delete();
      log_en = 1'b1;
      fork
         repeat (3) send_pkt(0, 2, -1, 0, -1, 0);
         repeat (3) send_pkt(1, 2, -1, 0, -1, 0);
         repeat (3) send_pkt(2, 2, -1, 0, -1, 0);
         repeat (3) send_pkt(3, 2, -1, 0, -1, 0);
      join
      drain();
      log_en = 1'b0;
      for (int i = 0; i < 12; i++) exp_order[i] = i % 4;
      chk("rr_order_len", 64'(tid_log.size()), 64'd12);
      for (int i = 0; i < 12 && i < tid_log.size(); i++)
         chk("rr_order", 64'(tid_log[i]), 64'(exp_order[i]));

      // Backpressure pattern mid-packet on requester 1.
      fork
         send_pkt(1, 6, 'h10, 0, -1, 0);
         begin
            repeat (3) @(posedge aclk);
            #1;
            m_tready = 1'b1; @(posedge aclk); #1;
            m_tready = 1'b0; @(posedge aclk); #1;
            m_tready = 1'b0; @(posedge aclk); #1;
            m_tready = 1'b1; @(posedge aclk); #1;
            m_tready = 1'b0; @(posedge aclk); #1;
            m_tready = 1'b1;
         end
      join
      drain();

      // Requester 3 stalls after its first beat while requester 0 waits.
      fork
         send_pkt(3, 3, 'h30, 0, 1, 6);
         begin
            repeat (3) @(posedge aclk);
            #1;
            send_pkt(0, 2, 'h50, 0, -1, 0);
         end
      join
      drain();

      // Randomized traffic with random backpressure.
      fork
         begin
            fork
               rand_req(0);
               rand_req(1);
               rand_req(2);
               rand_req(3);
            join
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               m_tready = ($urandom_range(3) != 0);
               @(posedge aclk); #1;
            end
         end
      join
      drain();

`ifdef HOST_ARB_STATS_EN
      do_reset();
      repeat (3) send_pkt(1, 5, -1, 0, -1, 0);
      drain();
      stats_sel = IB'(1);
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      chk("stats_pkts", 64'(stats_pkts), 64'd3);
      chk("stats_beats", 64'(stats_beats), 64'd15);
      stats_sel = IB'(5);
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      chk("stats_sel_oob", 64'(stats_beats), 64'd0);
      stats_sel = IB'(1);
      @(posedge aclk); #1;
      stats_clr = 1'b1;
      @(posedge aclk); #1;
      stats_clr = 1'b0;
      @(posedge aclk);
      @(negedge aclk);
      chk("stats_clr_pkts", 64'(stats_pkts), 64'd0);
      chk("stats_clr_beats", 64'(stats_beats), 64'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
